// File: rtl/md5_msg_gen_if.sv
// Candidate stream bus between the MD5 message generator and its controller/round pipeline.
// master = generator side, slave = controller/consumer side.
interface md5_msg_gen_if;
  logic         start;
  logic         halt;
  logic [511:0] m_out;
  logic [31:0]  a_out;
  logic [31:0]  b_out;
  logic [31:0]  c_out;
  logic [31:0]  d_out;
  logic         valid_out;
  logic [63:0]  cand_idx;
  logic         busy;
  logic         done;

  modport master (
    input  start, halt,
    output m_out, a_out, b_out, c_out, d_out, valid_out, cand_idx, busy, done
  );

  modport slave (
    output start, halt,
    input  m_out, a_out, b_out, c_out, d_out, valid_out, cand_idx, busy, done
  );
endinterface

// File: rtl/md5_msg_gen.sv
// Brute-force MD5 candidate generator: enumerates every LEN-byte string over NCHARS
// consecutive byte values, one padded 512-bit block per clock.
module md5_msg_gen #(
  parameter int         LEN        = 4,
  parameter logic [7:0] FIRST_CHAR = 8'h61,
  parameter int         NCHARS     = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  md5_msg_gen_if.master bus
);

  localparam int          OW        = 8 * LEN;
  localparam logic [7:0]  LAST_CHAR = 8'(int'(FIRST_CHAR) + NCHARS - 1);
  localparam logic [OW-1:0] FIRST_VEC = {LEN{FIRST_CHAR}};
  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  function automatic logic [63:0] cand_total();
    logic [63:0] t;
    t = 64'd1;
    for (int i = 0; i < LEN; i++) t = t * 64'(NCHARS);
    return t;
  endfunction

  localparam logic [63:0] LAST_IDX = cand_total() - 64'd1;

  // Odometer byte k lives at bits [8*(LEN-1-k) +: 8]; byte LEN-1 is the fastest digit.
  function automatic logic [OW-1:0] odo_inc(input logic [OW-1:0] v);
    logic [OW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int k = LEN - 1; k >= 0; k--) begin
      if (c) begin
        if (r[8*(LEN-1-k) +: 8] == LAST_CHAR) begin
          r[8*(LEN-1-k) +: 8] = FIRST_CHAR;
        end else begin
          r[8*(LEN-1-k) +: 8] = r[8*(LEN-1-k) +: 8] + 8'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Message byte k sits at [511-8k -: 8] so a per-word byte swap gives little-endian MD5 words.
  function automatic logic [511:0] build_block(input logic [OW-1:0] v);
    logic [511:0] b;
    b = '0;
    for (int k = 0; k < LEN; k++) b[511-8*k -: 8] = v[8*(LEN-1-k) +: 8];
    b[511-8*LEN -: 8] = 8'h80;
    b[63:56]          = 8'(LEN * 8);
    return b;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [OW-1:0] r_odo;
  logic [511:0]  r_m_p0;
  logic [63:0]   r_idx_p0;
  logic          r_vld_p0;
  logic [31:0]   r_a_p0, r_b_p0, r_c_p0, r_d_p0;
  logic          r_busy;
  logic          r_done;

  // Stage p0: odometer holds the next candidate; the output registers hold the current one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_odo    <= FIRST_VEC;
      r_m_p0   <= '0;
      r_idx_p0 <= '0;
      r_vld_p0 <= 1'b0;
      r_a_p0   <= '0;
      r_b_p0   <= '0;
      r_c_p0   <= '0;
      r_d_p0   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state  <= S_RUN;
            r_m_p0   <= build_block(FIRST_VEC);
            r_idx_p0 <= '0;
            r_odo    <= odo_inc(FIRST_VEC);
            r_vld_p0 <= 1'b1;
            r_a_p0   <= IV_A;
            r_b_p0   <= IV_B;
            r_c_p0   <= IV_C;
            r_d_p0   <= IV_D;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
          end
        end
        S_RUN: begin
          // Halt and end-of-space land in the same DONE state; the last block stays on m_out.
          if (bus.halt || (r_idx_p0 == LAST_IDX)) begin
            r_state  <= S_DONE;
            r_vld_p0 <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_m_p0   <= build_block(r_odo);
            r_idx_p0 <= r_idx_p0 + 64'd1;
            r_odo    <= odo_inc(r_odo);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.m_out     = r_m_p0;
  assign bus.cand_idx  = r_idx_p0;
  assign bus.valid_out = r_vld_p0;
  assign bus.a_out     = r_a_p0;
  assign bus.b_out     = r_b_p0;
  assign bus.c_out     = r_c_p0;
  assign bus.d_out     = r_d_p0;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_md5_msg_gen.sv
// Directed bench for md5_msg_gen at LEN=4, LEN=2 and LEN=8.
module tb_md5_msg_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  md5_msg_gen_if u_if4 ();
  md5_msg_gen_if u_if2 ();
  md5_msg_gen_if u_if8 ();

  md5_msg_gen #(.LEN(4), .FIRST_CHAR(8'h61), .NCHARS(26)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(u_if4.master));
  md5_msg_gen #(.LEN(2), .FIRST_CHAR(8'h61), .NCHARS(26)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(u_if2.master));
  md5_msg_gen #(.LEN(8), .FIRST_CHAR(8'h61), .NCHARS(26)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(u_if8.master));

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Padded LEN=4 block for a given 4-byte candidate word.
  function automatic logic [511:0] blk4(input logic [31:0] w);
    logic [511:0] b;
    b = '0;
    b[511:480] = w;
    b[479:472] = 8'h80;
    b[63:56]   = 8'h20;
    return b;
  endfunction

  int          cnt;
  logic [63:0] last_idx;
  logic [15:0] last_w;

  initial begin
    u_if4.start = 1'b0; u_if4.halt = 1'b0;
    u_if2.start = 1'b0; u_if2.halt = 1'b0;
    u_if8.start = 1'b0; u_if8.halt = 1'b0;
    repeat (3) tick();

    chk("rst_valid", 512'(u_if4.valid_out), 512'd0);
    chk("rst_busy",  512'(u_if4.busy),      512'd0);
    chk("rst_done",  512'(u_if4.done),      512'd0);
    chk("rst_idx",   512'(u_if4.cand_idx),  512'd0);
    chk("rst_m",     u_if4.m_out,           512'd0);
    chk("rst_a",     512'(u_if4.a_out),     512'd0);

    rst_n = 1'b1;
    tick();
    chk("idle_valid", 512'(u_if4.valid_out), 512'd0);

    // LEN=4 first candidate
    u_if4.start = 1'b1;
    tick();
    u_if4.start = 1'b0;
    chk("first_valid", 512'(u_if4.valid_out), 512'd1);
    chk("first_busy",  512'(u_if4.busy),      512'd1);
    chk("first_m",     u_if4.m_out,           blk4(32'h61616161));
    chk("first_idx",   512'(u_if4.cand_idx),  512'd0);
    chk("iv_a", 512'(u_if4.a_out), 512'(32'h67452301));
    chk("iv_b", 512'(u_if4.b_out), 512'(32'hefcdab89));
    chk("iv_c", 512'(u_if4.c_out), 512'(32'h98badcfe));
    chk("iv_d", 512'(u_if4.d_out), 512'(32'h10325476));

    repeat (25) tick();
    chk("aaaz_m",   u_if4.m_out,          blk4(32'h6161617a));
    chk("aaaz_idx", 512'(u_if4.cand_idx), 512'd25);
    tick();
    chk("aaba_m",   u_if4.m_out,          blk4(32'h61616261));
    chk("aaba_idx", 512'(u_if4.cand_idx), 512'd26);

    // start during RUN is ignored
    u_if4.start = 1'b1;
    tick();
    u_if4.start = 1'b0;
    chk("norestart_m",   u_if4.m_out,          blk4(32'h61616262));
    chk("norestart_idx", 512'(u_if4.cand_idx), 512'd27);

    repeat (73) tick();
    chk("idx100_m",   u_if4.m_out,          blk4(32'h61616477));
    chk("idx100_idx", 512'(u_if4.cand_idx), 512'd100);

    u_if4.halt = 1'b1;
    tick();
    u_if4.halt = 1'b0;
    chk("halt_valid", 512'(u_if4.valid_out), 512'd0);
    chk("halt_done",  512'(u_if4.done),      512'd1);
    chk("halt_busy",  512'(u_if4.busy),      512'd0);
    chk("halt_idx",   512'(u_if4.cand_idx),  512'd100);
    tick();
    chk("hold_idx", 512'(u_if4.cand_idx), 512'd100);
    chk("hold_m",   u_if4.m_out,          blk4(32'h61616477));

    u_if4.start = 1'b1;
    tick();
    u_if4.start = 1'b0;
    chk("restart_valid", 512'(u_if4.valid_out), 512'd1);
    chk("restart_done",  512'(u_if4.done),      512'd0);
    chk("restart_idx",   512'(u_if4.cand_idx),  512'd0);
    chk("restart_m",     u_if4.m_out,           blk4(32'h61616161));

    // reset mid-run
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", 512'(u_if4.valid_out), 512'd0);
    chk("midrst_busy",  512'(u_if4.busy),      512'd0);
    chk("midrst_done",  512'(u_if4.done),      512'd0);
    chk("midrst_idx",   512'(u_if4.cand_idx),  512'd0);
    chk("midrst_m",     u_if4.m_out,           512'd0);
    chk("midrst_d",     512'(u_if4.d_out),     512'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("postrst_valid", 512'(u_if4.valid_out), 512'd0);

    // LEN=2 full enumeration
    u_if2.start = 1'b1;
    tick();
    u_if2.start = 1'b0;
    cnt = 0;
    last_idx = '0;
    last_w = '0;
    for (int i = 0; i < 1000 && u_if2.valid_out; i++) begin
      cnt++;
      last_idx = u_if2.cand_idx;
      last_w   = u_if2.m_out[511:496];
      tick();
    end
    chk("len2_count",  512'(cnt),             512'd676);
    chk("len2_lastidx", 512'(last_idx),       512'd675);
    chk("len2_lastw",  512'(last_w),          512'(16'h7a7a));
    chk("len2_done",   512'(u_if2.done),      512'd1);
    chk("len2_busy",   512'(u_if2.busy),      512'd0);
    chk("len2_valid",  512'(u_if2.valid_out), 512'd0);
    tick();
    chk("len2_nowrap", 512'(u_if2.valid_out), 512'd0);

    // LEN=2 halt coinciding with last candidate
    u_if2.start = 1'b1;
    tick();
    u_if2.start = 1'b0;
    repeat (675) tick();
    chk("len2b_idx", 512'(u_if2.cand_idx), 512'd675);
    u_if2.halt = 1'b1;
    tick();
    u_if2.halt = 1'b0;
    chk("len2b_valid", 512'(u_if2.valid_out), 512'd0);
    chk("len2b_done",  512'(u_if2.done),      512'd1);
    chk("len2b_hold",  512'(u_if2.cand_idx),  512'd675);

    // LEN=8 padding
    u_if8.start = 1'b1;
    tick();
    u_if8.start = 1'b0;
    chk("len8_cand", 512'(u_if8.m_out[511:448]), 512'(64'h6161616161616161));
    chk("len8_pad",  512'(u_if8.m_out[447:440]), 512'(8'h80));
    chk("len8_len",  512'(u_if8.m_out[63:56]),   512'(8'h40));
    tick();
    chk("len8_b7",   512'(u_if8.m_out[455:448]), 512'(8'h62));
    chk("len8_idx",  512'(u_if8.cand_idx),       512'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
